// File: rtl/uart_tx_fifo_drain.sv
// 8N1 UART transmitter that pops bytes from the UART FIFO read port and
// serializes them back-to-back on the tx pin while transmission is enabled.
module uart_tx_fifo_drain #(
    parameter int BAUD_DIV = 10417
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_en,
    input  logic       i_fifo_empty,
    input  logic [7:0] i_fifo_r_data,
    output logic       o_fifo_r_en,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shreg;
    logic             r_tx;

    logic w_bit_end;
    logic w_pop;

    assign w_bit_end = (r_baud_cnt == BAUD_LAST);

    // Pops are only allowed from IDLE or in the final clock of a stop bit,
    // which gives at most one pop per frame and gap-free back-to-back frames.
    assign w_pop = ~i_rst & i_tx_en & ~i_fifo_empty &
                   ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));

    assign o_fifo_r_en = w_pop;
    assign o_tx        = r_tx;
    assign o_tx_busy   = (r_state != IDLE);
    assign o_tx_done   = (r_state == STOP) & w_bit_end;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_shreg    <= 8'h00;
            r_tx       <= 1'b1;
        end else begin
            if (r_state != IDLE) begin
                r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shreg    <= i_fifo_r_data;
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= 3'd0;
                        r_state    <= START;
                        r_tx       <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_tx    <= r_shreg[0];
                    end
                end
                DATA: begin
                    // tx is registered, so it is loaded with the bit that becomes shreg[0] after the shift.
                    if (w_bit_end) begin
                        r_shreg   <= {1'b0, r_shreg[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_tx <= r_shreg[1];
                        end
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shreg    <= i_fifo_r_data;
                            r_baud_cnt <= '0;
                            r_bit_cnt  <= 3'd0;
                            r_state    <= START;
                            r_tx       <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed testbench for uart_tx_fifo_drain: one instance at BAUD_DIV=4 and
// one at BAUD_DIV=1, checked with immediate assertions in the low clock phase.
module tb_uart_tx_fifo_drain;

    logic       clk;
    logic       aRst, aTxEn, aEmpty;
    logic [7:0] aData;
    logic       aREn, aTx, aBusy, aDone;
    logic       bRst, bTxEn, bEmpty;
    logic [7:0] bData;
    logic       bREn, bTx, bBusy, bDone;

    int compared   = 0;
    int mismatched = 0;

    uart_tx_fifo_drain #(.BAUD_DIV(4)) dutA (
        .i_clk         (clk),
        .i_rst         (aRst),
        .i_tx_en       (aTxEn),
        .i_fifo_empty  (aEmpty),
        .i_fifo_r_data (aData),
        .o_fifo_r_en   (aREn),
        .o_tx          (aTx),
        .o_tx_busy     (aBusy),
        .o_tx_done     (aDone)
    );

    uart_tx_fifo_drain #(.BAUD_DIV(1)) dutB (
        .i_clk         (clk),
        .i_rst         (bRst),
        .i_tx_en       (bTxEn),
        .i_fifo_empty  (bEmpty),
        .i_fifo_r_data (bData),
        .o_fifo_r_en   (bREn),
        .o_tx          (bTx),
        .o_tx_busy     (bBusy),
        .o_tx_done     (bDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level for bit slot idx of an 8N1 frame: start, D0..D7, stop.
    function automatic logic frameBit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic txEn, input logic empty, input logic [7:0] data);
        aRst   = rst;
        aTxEn  = txEn;
        aEmpty = empty;
        aData  = data;
    endtask

    task automatic checkIdleA(input string tag);
        checkOutput({tag, "_tx"}, aTx, 1'b1);
        checkOutput({tag, "_busy"}, aBusy, 1'b0);
        checkOutput({tag, "_rEn"}, aREn, 1'b0);
        checkOutput({tag, "_done"}, aDone, 1'b0);
    endtask

    // Walks the 40 cycles of a BAUD_DIV=4 frame that starts after the current pop cycle.
    task automatic runFrame(input logic [7:0] b, input int dropEnAt, input bit expectPop,
                            input bit emptyAtStart, input logic [7:0] nextData);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (emptyAtStart) aEmpty = 1'b1;
                else aData = nextData;
            end
            if (c == dropEnAt) aTxEn = 1'b0;
            #1;
            checkOutput("frame_tx", aTx, frameBit(b, (c - 1) / 4));
            checkOutput("frame_busy", aBusy, 1'b1);
            checkOutput("frame_done", aDone, (c == 40));
            checkOutput("frame_rEn", aREn, (c == 40) && expectPop);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hA5);
        bRst = 1'b1; bTxEn = 1'b0; bEmpty = 1'b1; bData = 8'h00;

        // Reset held three cycles with a non-empty FIFO and tx enabled.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checkIdleA("reset");
        end
        bRst = 1'b0;

        // First pop happens in the first cycle after reset falls; single byte 0xA5.
        @(negedge clk);
        aRst = 1'b0;
        #1;
        checkOutput("firstPop_rEn", aREn, 1'b1);
        checkOutput("firstPop_tx", aTx, 1'b1);
        runFrame(8'hA5, 0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checkIdleA("afterA5");
        end

        // Back-to-back 0x00 then 0xFF with the FIFO refilled during the first frame.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        #1;
        checkOutput("b2bPop_rEn", aREn, 1'b1);
        runFrame(8'h00, 0, 1'b1, 1'b0, 8'hFF);
        runFrame(8'hFF, 0, 1'b0, 1'b1, 8'h00);
        @(negedge clk); #1;
        checkIdleA("afterB2b");

        // tx_en low with data available: nothing is popped.
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h5A);
        for (int i = 0; i < 100; i++) begin
            #1;
            checkOutput("gated_rEn", aREn, 1'b0);
            checkOutput("gated_tx", aTx, 1'b1);
            @(negedge clk);
        end
        aTxEn = 1'b1;
        #1;
        checkOutput("enPop_rEn", aREn, 1'b1);
        // tx_en drops during data bit 2; frame completes, then no pop though FIFO stays non-empty.
        runFrame(8'h5A, 14, 1'b0, 1'b0, 8'h5A);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            checkIdleA("afterDrop");
        end

        // Reset asserted during data bit 3 of a 0xC3 frame.
        aTxEn = 1'b1;
        aData = 8'hC3;
        #1;
        checkOutput("rstPop_rEn", aREn, 1'b1);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) aData = 8'h99;
            #1;
            checkOutput("preRst_tx", aTx, frameBit(8'hC3, (c - 1) / 4));
        end
        aRst = 1'b1;
        #1;
        checkOutput("rstAssert_rEn", aREn, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            checkIdleA("midRst");
        end
        @(negedge clk);
        aRst = 1'b0;
        #1;
        checkOutput("postRstPop_rEn", aREn, 1'b1);
        runFrame(8'h99, 0, 1'b0, 1'b1, 8'h00);
        @(negedge clk); #1;
        checkIdleA("afterRst");

        // BAUD_DIV=1: 0x3C then 0x81 back-to-back, one clock per bit.
        @(negedge clk);
        bTxEn = 1'b1; bEmpty = 1'b0; bData = 8'h3C;
        #1;
        checkOutput("div1Pop_rEn", bREn, 1'b1);
        for (int f = 0; f < 2; f++) begin
            for (int c = 1; c <= 10; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    if (f == 0) bData = 8'h81;
                    else bEmpty = 1'b1;
                end
                #1;
                checkOutput("div1_tx", bTx, frameBit((f == 0) ? 8'h3C : 8'h81, c - 1));
                checkOutput("div1_done", bDone, (c == 10));
                checkOutput("div1_rEn", bREn, (c == 10) && (f == 0));
                checkOutput("div1_busy", bBusy, 1'b1);
            end
        end
        @(negedge clk); #1;
        checkOutput("div1Idle_busy", bBusy, 1'b0);
        checkOutput("div1Idle_tx", bTx, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

UART transmitter that drains the 8-deep UART FIFO from its read side. Whenever the FIFO is non-empty and transmission is enabled, the block pops one byte and serializes it as 8N1 on `tx`: one start bit, 8 data bits LSB first, one stop bit. Consecutive bytes go out back-to-back with no idle gap. It sits between the FIFO read port and the UART pin inside the AXI UART peripheral.

## Interface

Parameters:
- `BAUD_DIV`, default 10417. Clock cycles per bit (100 MHz / 9600). Legal range ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `tx_en`  in  1  allows new pops; a frame already started always completes.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_r_data`  in  8  FIFO head data; valid in the same cycle, combinational read.
- `fifo_r_en`  out  1  one-cycle pop strobe to the FIFO.
- `tx`  out  1  serial line, registered, idle high.
- `tx_busy`  out  1  high while a frame is in progress (START/DATA/STOP).
- `tx_done`  out  1  one-cycle pulse in the last clock of each stop bit.

## Operation

- Registers:
  - `state`
  - `baud_cnt`: width `$clog2(BAUD_DIV)`, minimum 1. Counts 0..BAUD_DIV-1.
  - `bit_cnt`: 3 bits.
  - `shreg`: 8 bits.
  - `tx` register.
- `bit_end` = (`baud_cnt` == BAUD_DIV-1). When `bit_end` is high, `baud_cnt` wraps to 0; otherwise it increments in every non-IDLE state.
- `pop` = `tx_en` & ~`fifo_empty` & (state==IDLE | (state==STOP & `bit_end`)).
  - `fifo_r_en` = `pop`, combinational.
  - On `pop`: `shreg` <= `fifo_r_data`, `baud_cnt` <= 0, `bit_cnt` <= 0, state <= START.
- State machine:
  - IDLE: `tx` = 1. Go to START on `pop`.
  - START: `tx` = 0. On `bit_end`, go to DATA.
  - DATA: `tx` = `shreg[0]`. On `bit_end`: shift `shreg` right, `bit_cnt`++; when `bit_cnt`==7, go to STOP.
  - STOP: `tx` = 1. On `bit_end`: go to START if `pop`, else IDLE.
- `tx` is registered: it takes the level of the state being entered or held.
- Outputs:
  - `tx_busy` = state != IDLE.
  - `tx_done` = (state==STOP) & `bit_end`.
- Pop rules:
  - At most one pop per frame.
  - No pop when `fifo_empty`=1 (underflow is impossible by construction).
  - No pop while `rst`=1.
- Boundary conditions:
  - `tx_en` falls mid-frame: the frame finishes normally, then the block goes to IDLE even if the FIFO is non-empty.
  - `fifo_empty` rises mid-frame: no effect on the current frame.
  - `rst` mid-frame: on the next edge, state=IDLE, `tx`=1, counters=0. The byte in flight is lost and not re-popped.
  - BAUD_DIV=1: `bit_end` is constantly 1; one bit per clock.

## Timing

- Reset values: state=IDLE, `tx`=1, `tx_busy`=0, `tx_done`=0, `fifo_r_en`=0, `baud_cnt`=0, `bit_cnt`=0, `shreg`=0.
- Pop latency:
  - In IDLE, `fifo_r_en` goes high in the same cycle `fifo_empty`=0 and `tx_en`=1. It is high for exactly one cycle.
  - `fifo_r_data` is captured at the end of that cycle.
- Start-bit latency: `tx` falls at the edge ending the pop cycle (pop cycle = N, start bit begins at N+1).
- Frame length: exactly 10×BAUD_DIV cycles.
  - Start bit occupies cycles N+1 .. N+BAUD_DIV.
  - Data bit k (0..7) occupies cycles N+1+(k+1)·BAUD_DIV onward, BAUD_DIV cycles each.
  - Stop bit occupies the last BAUD_DIV cycles.
- Back-to-back frames: the next pop occurs in the last stop cycle, which is also the `tx_done` cycle. The next start bit follows immediately, so the period is exactly 10×BAUD_DIV cycles with no idle cycle.
- From IDLE, a pop cannot coincide with `tx_done`.

## Test plan

All scenarios use BAUD_DIV=4 unless stated.
- **Reset:** hold `rst` 3 cycles with `fifo_empty`=0 and `tx_en`=1 → `tx`=1, `tx_busy`=0, `fifo_r_en`=0 throughout. First pop occurs in the first cycle after `rst` falls.
- **Single byte 0xA5:** `fifo_empty` falls for one byte → one `fifo_r_en` pulse. `tx` then carries 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total). `tx_done` pulses at cycle 40 after the pop, `tx_busy` falls at cycle 41, and no further pop occurs.
- **Back-to-back 0x00 then 0xFF:** the second `fifo_r_en` coincides with the first `tx_done`. `tx` rises for the stop bit, then falls for the second start bit with no gap. Total 80 cycles from the first start bit to the end of the second stop bit.
- **tx_en gating:** `tx_en`=0 with `fifo_empty`=0 for 100 cycles → no `fifo_r_en`, `tx`=1. Dropping `tx_en` during data bit 2 of a frame → the frame completes intact, then IDLE with no pop.
- **Reset mid-frame:** assert `rst` during data bit 3 → next edge `tx`=1, `tx_busy`=0, no pop during reset. After release, the next byte's frame is correct.
- **BAUD_DIV=1:** byte 0x3C → `tx` carries 0,0,0,1,1,1,1,0,0,1, one cycle per bit. Back-to-back frames are 10 cycles apart.
